audio_pwm_out: RTL and testbench

//   Consumer end of the filter's sample stream: takes each 8-bit unsigned sample
//   (sample_out + sample_valid of the filter) and turns it into a 1-bit PWM

---
 rtl/audio_pwm_out.sv | 118 +++++++++++
 tb/tb_audio_pwm_out.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_out.sv
// Sample-to-PWM stage: one 8-bit duty per 256-cycle period, with pop-free ramps and overrun/underrun flags.
// Samples are double-buffered and take effect at the first period boundary after arrival; there is no backpressure.
module audio_pwm_out #(
  parameter logic [7:0] MID       = 8'd128,
  parameter logic [7:0] RAMP_STEP = 8'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic       enable,
  input  logic       clr_flags,
  output logic       pwm_out,
  output logic       period_start,
  output logic       ramping,
  output logic       overrun,
  output logic       underrun
);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] duty, duty_nxt;
  logic [7:0] pend;
  logic       pend_full, pend_full_nxt;
  logic       boundary;
  logic       set_ov, set_un;
  logic [8:0] up_sum;

  assign boundary = (state != IDLE) && (cnt == 8'hFF);
  assign up_sum   = {1'b0, duty} + {1'b0, RAMP_STEP};
  // A sample landing on the boundary cycle never counts as an overwrite.
  assign set_ov   = sample_valid && pend_full && !boundary && (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    duty_nxt      = duty;
    pend_full_nxt = pend_full;
    set_un        = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (boundary) begin
          if (!enable) begin
            state_nxt = RAMP_DOWN;
          end else if (up_sum >= {1'b0, MID}) begin
            duty_nxt  = MID;
            state_nxt = RUN;
          end else begin
            duty_nxt = up_sum[7:0];
          end
        end
      end
      RUN: begin
        if (boundary) begin
          if (!enable) begin
            state_nxt     = RAMP_DOWN;
            pend_full_nxt = 1'b0;
          end else if (pend_full) begin
            duty_nxt      = pend;
            pend_full_nxt = 1'b0;
          end else begin
            set_un = 1'b1;
          end
        end
      end
      RAMP_DOWN: begin
        if (boundary) begin
          if (enable) begin
            state_nxt = RAMP_UP;
          end else if (duty <= RAMP_STEP) begin
            duty_nxt      = 8'd0;
            state_nxt     = IDLE;
            pend_full_nxt = 1'b0;
          end else begin
            duty_nxt = duty - RAMP_STEP;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A fresh sample always leaves the buffer full, even over a boundary consume.
    if (sample_valid) pend_full_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= 8'd0;
      duty         <= 8'd0;
      pend         <= 8'd0;
      pend_full    <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      ramping      <= 1'b0;
      overrun      <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      cnt          <= (state == IDLE) ? 8'd0 : cnt + 8'd1;
      duty         <= duty_nxt;
      pend_full    <= pend_full_nxt;
      if (sample_valid) pend <= sample_in;
      pwm_out      <= (state != IDLE) && (cnt < duty);
      period_start <= boundary;
      ramping      <= (state_nxt == RAMP_UP) || (state_nxt == RAMP_DOWN);
      overrun      <= set_ov | (overrun  & ~clr_flags);
      underrun     <= set_un | (underrun & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Bench for audio_pwm_out: period-level reference model, directed vector table, random RUN traffic.
module tb_audio_pwm_out;

  localparam int MIDV   = 128;
  localparam int STEPV  = 1;
  localparam int M_IDLE = 0, M_UP = 1, M_RUN = 2, M_DOWN = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sample_in;
  logic       sample_valid, enable, clr_flags;
  logic       pwm_out, period_start, ramping, overrun, underrun;

  always #5 clk = ~clk;

  audio_pwm_out dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .enable(enable), .clr_flags(clr_flags), .pwm_out(pwm_out), .period_start(period_start),
    .ramping(ramping), .overrun(overrun), .underrun(underrun)
  );

  typedef struct {
    int en, s0p, s0v, s1p, s1v, clrp;
    int highs, ov, un;
  } vec_t;

  vec_t tbl[8];
  int checks = 0;
  int errors = 0;
  int m_mode, m_duty, m_pend, m_full, m_ov, m_un;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model advances one whole PWM period; phases with no event change nothing.
  task automatic model_period(input int en, input int s0p, input int s0v,
                              input int s1p, input int s1v, input int clrp);
    for (int p = 0; p < 256; p++) begin
      bit sv, bnd, sov, sun;
      int v;
      sv  = (p == s0p) || (p == s1p);
      v   = (p == s0p) ? s0v : s1v;
      bnd = (p == 255) && (m_mode != M_IDLE);
      sov = sv && (m_full != 0) && !bnd && (m_mode == M_RUN);
      sun = 0;
      if (bnd) begin
        case (m_mode)
          M_UP: begin
            if (en == 0) m_mode = M_DOWN;
            else begin
              m_duty = (m_duty + STEPV > MIDV) ? MIDV : m_duty + STEPV;
              if (m_duty == MIDV) m_mode = M_RUN;
            end
          end
          M_RUN: begin
            if (en == 0) begin m_mode = M_DOWN; m_full = 0; end
            else if (m_full != 0) begin m_duty = m_pend; m_full = 0; end
            else sun = 1;
          end
          M_DOWN: begin
            if (en != 0) m_mode = M_UP;
            else begin
              m_duty = (m_duty - STEPV < 0) ? 0 : m_duty - STEPV;
              if (m_duty == 0) begin m_mode = M_IDLE; m_full = 0; end
            end
          end
          default: ;
        endcase
      end
      if (sv) begin m_pend = v; m_full = 1; end
      if (p == clrp) begin m_ov = 0; m_un = 0; end
      if (sov) m_ov = 1;
      if (sun) m_un = 1;
    end
  endtask

  // Starts at the negedge of a cycle with cnt==0; ends at the next one.
  task automatic run_period(input int en, input int s0p, input int s0v, input int s1p,
                            input int s1v, input int clrp,
                            output int highs, output int ps_mid, output int ps_end);
    highs = 0; ps_mid = 0;
    for (int p = 0; p < 256; p++) begin
      highs += int'(pwm_out);
      if (p != 0) ps_mid += int'(period_start);
      enable       = (en != 0);
      sample_valid = (p == s0p) || (p == s1p);
      sample_in    = (p == s0p) ? 8'(s0v) : (p == s1p) ? 8'(s1v) : 8'd0;
      clr_flags    = (p == clrp);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    clr_flags    = 1'b0;
    ps_end = int'(period_start);
  endtask

  task automatic period_vs_model(input string tag, input int en, input int s0p, input int s0v,
                                 input int s1p, input int s1v, input int clrp);
    int highs, ps_mid, ps_end, exp_highs;
    exp_highs = m_duty;
    run_period(en, s0p, s0v, s1p, s1v, clrp, highs, ps_mid, ps_end);
    model_period(en, s0p, s0v, s1p, s1v, clrp);
    check({tag, "_highs"}, highs, exp_highs);
    check({tag, "_overrun"}, int'(overrun), m_ov);
    check({tag, "_underrun"}, int'(underrun), m_un);
    check({tag, "_ramping"}, int'(ramping), int'(m_mode == M_UP || m_mode == M_DOWN));
    check({tag, "_pstart"}, ps_end * 2 + ps_mid, 2);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pwm"}, int'(pwm_out), 0);
    check({tag, "_pstart"}, int'(period_start), 0);
    check({tag, "_ramping"}, int'(ramping), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_underrun"}, int'(underrun), 0);
  endtask

  initial begin
    int bad, n, highs, ps_mid, ps_end;
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_in = 8'd0; clr_flags = 1'b0;

    //            en  s0p  s0v  s1p  s1v  clr  highs ov un
    tbl[0] = '{1,  -1,  0,   -1,  0,   -1,  128,  0, 1};
    tbl[1] = '{1,  100, 8'h40, -1, 0,  10,  128,  0, 0};
    tbl[2] = '{1,  7,   8'hFF, -1, 0,  -1,  64,   0, 0};
    tbl[3] = '{1,  200, 8'h00, -1, 0,  -1,  255,  0, 0};
    tbl[4] = '{1,  50,  8'h10, 150, 8'h20, -1, 0, 1, 0};
    tbl[5] = '{1,  20,  8'h30, 255, 8'h55, 5,  32, 0, 0};
    tbl[6] = '{1,  -1,  0,   -1,  0,   -1,  48,   0, 0};
    tbl[7] = '{1,  128, 8'h50, -1, 0,  -1,  85,   0, 0};

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    check("reset_cnt", int'(dut.cnt), 0);
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      clr_flags = (i % 97 == 0);
      if (pwm_out || period_start || ramping || overrun || underrun) bad++;
      if (dut.cnt != 8'd0) bad++;
    end
    clr_flags = 1'b0;
    check("idle_quiet", bad, 0);

    m_mode = M_IDLE; m_duty = 0; m_pend = 0; m_full = 0; m_ov = 0; m_un = 0;

    enable = 1'b1;
    @(negedge clk);
    m_mode = M_UP;
    n = 0;
    while (m_mode == M_UP && n < 200) begin
      period_vs_model("ramp_up", 1, -1, 0, -1, 0, -1);
      n++;
    end

    for (int i = 0; i < 8; i++) begin
      run_period(tbl[i].en, tbl[i].s0p, tbl[i].s0v, tbl[i].s1p, tbl[i].s1v, tbl[i].clrp,
                 highs, ps_mid, ps_end);
      model_period(tbl[i].en, tbl[i].s0p, tbl[i].s0v, tbl[i].s1p, tbl[i].s1v, tbl[i].clrp);
      check($sformatf("vec%0d_highs", i), highs, tbl[i].highs);
      check($sformatf("vec%0d_overrun", i), int'(overrun), tbl[i].ov);
      check($sformatf("vec%0d_underrun", i), int'(underrun), tbl[i].un);
      check($sformatf("vec%0d_ramping", i), int'(ramping), 0);
      check($sformatf("vec%0d_pstart", i), ps_end * 2 + ps_mid, 2);
    end

    for (int i = 0; i < 24; i++) begin
      int ns, p0, p1, v0, v1, cp;
      ns = int'($urandom_range(0, 2));
      p0 = (ns >= 1) ? int'($urandom_range(0, 255)) : -1;
      p1 = (ns == 2) ? (p0 + 1 + int'($urandom_range(0, 254))) % 256 : -1;
      v0 = int'($urandom_range(0, 255));
      v1 = int'($urandom_range(0, 255));
      cp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
      period_vs_model($sformatf("rand%0d", i), 1, p0, v0, p1, v1, cp);
    end

    period_vs_model("pre_down", 1, 60, 8'h50, -1, 0, 0);
    n = 0;
    while (m_mode != M_IDLE && n < 100) begin
      period_vs_model("ramp_down", (n == 40) ? 1 : 0, -1, 0, -1, 0, -1);
      n++;
    end

    bad = 0;
    enable = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pwm_out || ramping || dut.cnt != 8'd0) bad++;
      @(negedge clk);
    end
    check("after_down_idle", bad, 0);

    enable = 1'b1;
    @(negedge clk);
    m_mode = M_UP;
    for (int k = 0; k < 3; k++) period_vs_model("rst_ramp", 1, -1, 0, -1, 0, -1);
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_pwm", int'(pwm_out), 1);
    check("pre_rst_ramping", int'(ramping), 1);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pwm_out || period_start || ramping || overrun || underrun) bad++;
    end
    check("post_rst_quiet", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
